control_unit: RTL and testbench
===============================

Name: control_unit

Overview:
- Multi-cycle FSM sequencer for the 11-bit accumulator processor datapath.
- Decodes the 5-bit opcode held in the instruction register and drives the datapath write strobes and selects: IR, PC, ACC, data memory, ALU and status register.
- Reads flag_Z/flag_N from the status register to resolve conditional branches.
- One instruction retires every 3 cycles: FETCH, DECODE, EXECUTE.

Parameters:
- OPCODE_WIDTH, 5, width of opcode_in.
- DATA_WIDTH, 11, datapath width; documentation/consistency only, no port depends on it.

Ports:
- clock  input  1  system clock; all state changes on its rising edge.
- control_reset  input  1  synchronous, active-low reset.
- run  input  1  1 = fetch new instructions; 0 = park in IDLE between instructions.
- opcode_in  input  OPCODE_WIDTH  opcode field of the IR output.
- flag_Z  input  1  zero flag from the status register.
- flag_N  input  1  negative flag from the status register.
- ir_wr  output  1  load IR from instruction memory.
- pc_wr  output  1  update PC.
- pc_sel  output  1  0 = PC+1, 1 = operand (branch target).
- acc_wr  output  1  load ACC.
- acc_sel  output  2  00 = ALU result, 01 = data memory, 10 = immediate operand.
- alu_op  output  1  0 = add, 1 = subtract.
- op_sel  output  1  ALU B operand: 0 = data memory, 1 = immediate.
- mem_wr  output  1  write ACC to data memory at the operand address.
- status_wr  output  1  write status register (Z/N).
- halted  output  1  FSM is in HALT.

Behaviour:
- States: INIT, IDLE, FETCH, DECODE, EXECUTE, HALT. Encoding is free.
- Reset: control_reset==0 at an edge -> state=INIT. While in INIT, all outputs are 0.
- All outputs are combinational decodes of (state, opcode_in). Strobes are 1 only in the states listed below; otherwise 0.
- INIT -> IDLE unconditionally.
- IDLE -> FETCH if run==1, else stay in IDLE.
- FETCH: ir_wr=1; next state DECODE. The IR captures at the end of FETCH, so opcode_in is valid from DECODE onward.
- DECODE: no strobes; selects are driven for the decoded opcode; data memory read of the operand address is in flight. Next state EXECUTE.
- EXECUTE, by opcode:
  - HLT 00000: no strobes; next state HALT.
  - STO 00001: mem_wr=1, pc_wr=1, pc_sel=0.
  - LD 00010: acc_wr=1, acc_sel=01, pc_wr=1.
  - LDI 00011: acc_wr=1, acc_sel=10, pc_wr=1.
  - ADD 00100 / ADDI 00101 / SUB 00110 / SUBI 00111: acc_wr=1, acc_sel=00, status_wr=1, pc_wr=1. alu_op=opcode[1]; op_sel=opcode[0].
  - BEQ 01000 (Z), BNE 01001 (!Z), BGT 01010 (!Z&!N), BGE 01011 (!N), BLT 01100 (N), BLE 01101 (Z|N): pc_wr=1, pc_sel=condition.
  - JMP 01110: pc_wr=1, pc_sel=1.
  - Other opcodes: NOP (pc_wr=1, pc_sel=0) unless the optional feature is enabled.
- EXECUTE next state (non-HLT): FETCH if run==1, else IDLE.
- run is sampled only in IDLE and at the end of EXECUTE. Deasserting run mid-instruction completes that instruction.
- Flags are sampled combinationally in EXECUTE. A status_wr issued in instruction k's EXECUTE is visible to instruction k+1's branch.
- HALT: halted=1, all strobes 0. Left only via control_reset==0.
- Reset during any state, including mid-EXECUTE, aborts: INIT on the next edge, and no strobe is asserted in the cycle after the reset edge.

Optional Feature:
- CONTROL_ILLEGAL_TRAP_EN defined:
  - Adds output illegal_op (1 bit).
  - An undefined opcode in EXECUTE -> no strobes, next state HALT; illegal_op=1 while in HALT from that cause.
  - illegal_op is cleared only by reset.
- Undefined: undefined opcodes execute as NOP; the illegal_op port does not exist.

Decomposition:
- Package control_pkg holds:
  - opcode enum/localparams;
  - state enum;
  - acc_sel constants (ACC_SEL_ALU, ACC_SEL_MEM, ACC_SEL_IMM);
  - ALU_ADD/ALU_SUB.
- One sub-module: branch_eval. Combinational; (opcode, flag_Z, flag_N) -> take_branch. It is reused by the verification model.

Test Plan:
- Hold control_reset=0 for 3 cycles, then release with run=1 -> all outputs 0 while in reset and in INIT. IDLE on the next cycle, FETCH after that, with ir_wr=1 in FETCH.
- opcode_in=00101 (ADDI), run=1 -> ir_wr in cycle 0. In cycle 2: acc_wr=1, acc_sel=00, alu_op=0, op_sel=1, status_wr=1, pc_wr=1, pc_sel=0. Period is exactly 3 cycles.
- BLT (01100) with N=1,Z=0 -> EXECUTE pc_wr=1, pc_sel=1. With N=0 -> pc_sel=0. Repeat for all six conditions over all four (Z,N) combinations.
- STO (00001) -> mem_wr=1 only in EXECUTE; acc_wr=0, status_wr=0.
- run dropped during DECODE of SUB -> SUB completes in EXECUTE, then IDLE (ir_wr=0). Raising run -> FETCH next cycle.
- HLT (00000) -> HALT, halted=1, no pc_wr; stays despite run=1 until reset. With CONTROL_ILLEGAL_TRAP_EN, opcode 11111 -> HALT with illegal_op=1; without the macro, 11111 -> pc_wr=1, pc_sel=0.

Source files
------------

// File: rtl/control_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : control_pkg
//  Description : Shared encodings for the accumulator-processor control unit:
//                FSM states, opcodes, ACC source selects and ALU operations.
//  Revision    : 1.0 - initial release
// ============================================================================
package control_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_INIT    = 3'd0,
        ST_IDLE    = 3'd1,
        ST_FETCH   = 3'd2,
        ST_DECODE  = 3'd3,
        ST_EXECUTE = 3'd4,
        ST_HALT    = 3'd5
    } state_t;

    // Instruction opcodes
    localparam logic [4:0] OP_HLT  = 5'b00000;
    localparam logic [4:0] OP_STO  = 5'b00001;
    localparam logic [4:0] OP_LD   = 5'b00010;
    localparam logic [4:0] OP_LDI  = 5'b00011;
    localparam logic [4:0] OP_ADD  = 5'b00100;
    localparam logic [4:0] OP_ADDI = 5'b00101;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_SUBI = 5'b00111;
    localparam logic [4:0] OP_BEQ  = 5'b01000;
    localparam logic [4:0] OP_BNE  = 5'b01001;
    localparam logic [4:0] OP_BGT  = 5'b01010;
    localparam logic [4:0] OP_BGE  = 5'b01011;
    localparam logic [4:0] OP_BLT  = 5'b01100;
    localparam logic [4:0] OP_BLE  = 5'b01101;
    localparam logic [4:0] OP_JMP  = 5'b01110;

    // ACC load source
    localparam logic [1:0] ACC_SEL_ALU = 2'b00;
    localparam logic [1:0] ACC_SEL_MEM = 2'b01;
    localparam logic [1:0] ACC_SEL_IMM = 2'b10;

    // ALU operation
    localparam logic ALU_ADD = 1'b0;
    localparam logic ALU_SUB = 1'b1;

endpackage
`default_nettype wire

// File: rtl/branch_eval.sv
`default_nettype none
// ============================================================================
//  Module      : branch_eval
//  Description : Combinational branch-condition evaluator. Maps a branch
//                opcode and the Z/N status flags to a take/no-take decision.
//                Non-branch opcodes evaluate to "not taken".
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_eval
    import control_pkg::*;
(
    input  logic [4:0] opcode,
    input  logic       flag_Z,
    input  logic       flag_N,
    output logic       take_branch
);

    // Condition table for the conditional branches and the unconditional jump
    always_comb begin
        take_branch = 1'b0;
        case (opcode)
            OP_BEQ:  take_branch = flag_Z;
            OP_BNE:  take_branch = ~flag_Z;
            OP_BGT:  take_branch = ~flag_Z & ~flag_N;
            OP_BGE:  take_branch = ~flag_N;
            OP_BLT:  take_branch = flag_N;
            OP_BLE:  take_branch = flag_Z | flag_N;
            OP_JMP:  take_branch = 1'b1;
            default: take_branch = 1'b0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : control_unit
//  Description : Three-cycle (FETCH/DECODE/EXECUTE) sequencer for the 11-bit
//                accumulator datapath. Outputs are combinational decodes of
//                the current state and the IR opcode.
//                Optional macro CONTROL_ILLEGAL_TRAP_EN: undefined opcodes
//                halt the machine and raise illegal_op instead of acting
//                as NOP.
//  Revision    : 1.0 - initial release
// ============================================================================
module control_unit
    import control_pkg::*;
#(
    parameter int OPCODE_WIDTH = 5,
    parameter int DATA_WIDTH   = 11
)
(
    input  logic                    clock,
    input  logic                    control_reset,
    input  logic                    run,
    input  logic [OPCODE_WIDTH-1:0] opcode_in,
    input  logic                    flag_Z,
    input  logic                    flag_N,
    output logic                    ir_wr,
    output logic                    pc_wr,
    output logic                    pc_sel,
    output logic                    acc_wr,
    output logic [1:0]              acc_sel,
    output logic                    alu_op,
    output logic                    op_sel,
    output logic                    mem_wr,
    output logic                    status_wr,
    output logic                    halted
`ifdef CONTROL_ILLEGAL_TRAP_EN
    ,
    output logic                    illegal_op
`endif
);

    // The opcode must fit inside a datapath word alongside its operand
    if (DATA_WIDTH <= OPCODE_WIDTH) begin : g_width_check
        $error("control_unit: DATA_WIDTH must exceed OPCODE_WIDTH");
    end

    state_t     r_state;
    state_t     w_next_state;

    logic       w_take_branch;
    logic       w_halt_op;
    logic       w_pc_ld;
    logic       w_pc_target;
    logic       w_acc_ld;
    logic [1:0] w_acc_src;
    logic       w_alu_fn;
    logic       w_imm_b;
    logic       w_mem_st;
    logic       w_status_ld;
`ifdef CONTROL_ILLEGAL_TRAP_EN
    logic       w_defined;
    logic       w_trap;
    logic       r_illegal;
`endif

    branch_eval u_branch_eval (
        .opcode      (opcode_in),
        .flag_Z      (flag_Z),
        .flag_N      (flag_N),
        .take_branch (w_take_branch)
    );

    // Opcode decode into per-instruction strobe requests and selects
    always_comb begin
        w_halt_op   = 1'b0;
        w_pc_ld     = 1'b0;
        w_pc_target = 1'b0;
        w_acc_ld    = 1'b0;
        w_acc_src   = ACC_SEL_ALU;
        w_alu_fn    = ALU_ADD;
        w_imm_b     = 1'b0;
        w_mem_st    = 1'b0;
        w_status_ld = 1'b0;
`ifdef CONTROL_ILLEGAL_TRAP_EN
        w_defined   = 1'b1;
`endif
        case (opcode_in)
            OP_HLT: w_halt_op = 1'b1;
            OP_STO: begin
                w_mem_st = 1'b1;
                w_pc_ld  = 1'b1;
            end
            OP_LD: begin
                w_acc_ld  = 1'b1;
                w_acc_src = ACC_SEL_MEM;
                w_pc_ld   = 1'b1;
            end
            OP_LDI: begin
                w_acc_ld  = 1'b1;
                w_acc_src = ACC_SEL_IMM;
                w_pc_ld   = 1'b1;
            end
            OP_ADD, OP_ADDI, OP_SUB, OP_SUBI: begin
                w_acc_ld    = 1'b1;
                w_acc_src   = ACC_SEL_ALU;
                w_status_ld = 1'b1;
                w_pc_ld     = 1'b1;
                // opcode bit 1 picks subtract, bit 0 picks the immediate operand
                w_alu_fn    = opcode_in[1] ? ALU_SUB : ALU_ADD;
                w_imm_b     = opcode_in[0];
            end
            OP_BEQ, OP_BNE, OP_BGT, OP_BGE, OP_BLT, OP_BLE, OP_JMP: begin
                w_pc_ld     = 1'b1;
                w_pc_target = w_take_branch;
            end
            default: begin
`ifdef CONTROL_ILLEGAL_TRAP_EN
                w_defined = 1'b0;
`endif
                // Undefined opcodes behave as NOP: just advance the PC
                w_pc_ld = 1'b1;
            end
        endcase
    end

    // State register; reset aborts any instruction in flight
    always_ff @(posedge clock) begin
        if (!control_reset) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and output decode
    always_comb begin
        w_next_state = r_state;
        ir_wr        = 1'b0;
        pc_wr        = 1'b0;
        pc_sel       = 1'b0;
        acc_wr       = 1'b0;
        acc_sel      = ACC_SEL_ALU;
        alu_op       = ALU_ADD;
        op_sel       = 1'b0;
        mem_wr       = 1'b0;
        status_wr    = 1'b0;
`ifdef CONTROL_ILLEGAL_TRAP_EN
        w_trap       = 1'b0;
`endif
        case (r_state)
            ST_INIT: w_next_state = ST_IDLE;
            ST_IDLE: begin
                if (run) begin
                    w_next_state = ST_FETCH;
                end
            end
            ST_FETCH: begin
                ir_wr        = 1'b1;
                w_next_state = ST_DECODE;
            end
            ST_DECODE: begin
                // Selects settle early while the operand read is in flight
                pc_sel       = w_pc_target;
                acc_sel      = w_acc_src;
                alu_op       = w_alu_fn;
                op_sel       = w_imm_b;
                w_next_state = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                pc_sel  = w_pc_target;
                acc_sel = w_acc_src;
                alu_op  = w_alu_fn;
                op_sel  = w_imm_b;
                if (w_halt_op) begin
                    w_next_state = ST_HALT;
                end
`ifdef CONTROL_ILLEGAL_TRAP_EN
                else if (!w_defined) begin
                    w_trap       = 1'b1;
                    w_next_state = ST_HALT;
                end
`endif
                else begin
                    pc_wr        = w_pc_ld;
                    acc_wr       = w_acc_ld;
                    mem_wr       = w_mem_st;
                    status_wr    = w_status_ld;
                    w_next_state = run ? ST_FETCH : ST_IDLE;
                end
            end
            ST_HALT: w_next_state = ST_HALT;
            default: w_next_state = ST_INIT;
        endcase
    end

    assign halted = (r_state == ST_HALT);

`ifdef CONTROL_ILLEGAL_TRAP_EN
    // Sticky trap cause; only a reset clears it
    always_ff @(posedge clock) begin
        if (!control_reset) begin
            r_illegal <= 1'b0;
        end else if (w_trap) begin
            r_illegal <= 1'b1;
        end
    end

    assign illegal_op = r_illegal;
`endif

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_control_unit
//  Description : Self-checking bench for control_unit. A behavioural model
//                tracks the instruction phase and predicts the strobes and
//                selects each cycle from the instruction-set rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_control_unit;

    logic       clock = 1'b0;
    logic       control_reset;
    logic       run;
    logic [4:0] opcode_in;
    logic       flag_Z;
    logic       flag_N;
    logic       ir_wr, pc_wr, pc_sel, acc_wr, alu_op, op_sel, mem_wr, status_wr, halted;
    logic [1:0] acc_sel;
    logic       tb_illegal;

`ifdef CONTROL_ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
    logic illegal_op;
    assign tb_illegal = illegal_op;
`else
    localparam bit TRAP = 1'b0;
    assign tb_illegal = 1'b0;
`endif

    control_unit dut (
        .clock         (clock),
        .control_reset (control_reset),
        .run           (run),
        .opcode_in     (opcode_in),
        .flag_Z        (flag_Z),
        .flag_N        (flag_N),
        .ir_wr         (ir_wr),
        .pc_wr         (pc_wr),
        .pc_sel        (pc_sel),
        .acc_wr        (acc_wr),
        .acc_sel       (acc_sel),
        .alu_op        (alu_op),
        .op_sel        (op_sel),
        .mem_wr        (mem_wr),
        .status_wr     (status_wr),
        .halted        (halted)
`ifdef CONTROL_ILLEGAL_TRAP_EN
        ,
        .illegal_op    (illegal_op)
`endif
    );

    always #5 clock = ~clock;

    // Model phases (bench-local numbering)
    localparam int P_INIT = 0, P_IDLE = 1, P_FETCH = 2, P_DECODE = 3, P_EXEC = 4, P_HALT = 5;
    // Bit layout: ir pc_wr pc_sel acc_wr acc_sel[1:0] alu_op op_sel mem_wr status_wr halted illegal
    localparam logic [11:0] M_STROBES = 12'hD0F;

    int n_tests = 0;
    int n_fail  = 0;
    int m_phase;
    bit m_illegal;

    function automatic bit cond_of(input int op, input bit z, input bit n);
        case (op)
            8:       return z;
            9:       return !z;
            10:      return !z && !n;
            11:      return !n;
            12:      return n;
            13:      return z || n;
            default: return 1'b1;
        endcase
    endfunction

    task automatic tick(input string tag);
        logic [11:0] e, m, obs;
        int op;
        int nph;
        bit nill;
        @(negedge clock);
        op = int'(opcode_in);
        e  = 12'h000;
        m  = M_STROBES;
        case (m_phase)
            P_INIT:  m = 12'hFFF;
            P_FETCH: e[11] = 1'b1;
            P_HALT: begin
                e[1] = 1'b1;
                e[0] = m_illegal;
            end
            P_EXEC: begin
                if (op == 1) begin
                    e[3] = 1'b1; e[10] = 1'b1; m[9] = 1'b1;
                end else if (op == 2 || op == 3) begin
                    e[8] = 1'b1; e[10] = 1'b1; m[9] = 1'b1; m[7:6] = 2'b11;
                    e[7:6] = (op == 2) ? 2'b01 : 2'b10;
                end else if (op >= 4 && op <= 7) begin
                    e[8] = 1'b1; e[2] = 1'b1; e[10] = 1'b1;
                    m[9] = 1'b1; m[7:4] = 4'hF;
                    e[5] = ((op >> 1) & 1) != 0;
                    e[4] = (op & 1) != 0;
                end else if (op >= 8 && op <= 14) begin
                    e[10] = 1'b1; m[9] = 1'b1;
                    e[9]  = cond_of(op, flag_Z, flag_N);
                end else if (op >= 15 && !TRAP) begin
                    e[10] = 1'b1; m[9] = 1'b1;
                end
            end
            default: ;
        endcase
        obs = {ir_wr, pc_wr, pc_sel, acc_wr, acc_sel, alu_op, op_sel,
               mem_wr, status_wr, halted, tb_illegal};
        n_tests++;
        assert ((obs & m) === (e & m)) else begin
            n_fail++;
            $error("FAIL %s: phase=%0d op=%0d observed=%03h required=%03h mask=%03h",
                   tag, m_phase, op, obs & m, e & m, m);
        end
        // Advance the model using the inputs present at the coming edge
        nph  = m_phase;
        nill = m_illegal;
        if (!control_reset) begin
            nph  = P_INIT;
            nill = 1'b0;
        end else begin
            case (m_phase)
                P_INIT:   nph = P_IDLE;
                P_IDLE:   nph = run ? P_FETCH : P_IDLE;
                P_FETCH:  nph = P_DECODE;
                P_DECODE: nph = P_EXEC;
                P_EXEC: begin
                    if (op == 0) begin
                        nph = P_HALT;
                    end else if (TRAP && op >= 15) begin
                        nph  = P_HALT;
                        nill = 1'b1;
                    end else begin
                        nph = run ? P_FETCH : P_IDLE;
                    end
                end
                default:  nph = P_HALT;
            endcase
        end
        @(posedge clock);
        #1;
        m_phase   = nph;
        m_illegal = nill;
    endtask

    task automatic run_instr(input logic [4:0] op, input logic z, input logic n, input string tag);
        opcode_in = op;
        flag_Z    = z;
        flag_N    = n;
        repeat (3) tick(tag);
    endtask

    task automatic restart();
        control_reset = 1'b0;
        tick("reset");
        control_reset = 1'b1;
        run = 1'b1;
        tick("init");
        tick("idle");
    endtask

    initial begin
        control_reset = 1'b0;
        run           = 1'b1;
        opcode_in     = 5'b00101;
        flag_Z        = 1'b0;
        flag_N        = 1'b0;
        @(posedge clock);
        #1;
        m_phase   = P_INIT;
        m_illegal = 1'b0;

        // Reset hold and bring-up
        repeat (3) tick("reset_hold");
        control_reset = 1'b1;
        tick("init");
        tick("idle");

        // Back-to-back ADDI, then each non-branch instruction
        run_instr(5'b00101, 1'b0, 1'b0, "addi_a");
        run_instr(5'b00101, 1'b1, 1'b1, "addi_b");
        run_instr(5'b00001, 1'b0, 1'b0, "sto");
        run_instr(5'b00010, 1'b0, 1'b0, "ld");
        run_instr(5'b00011, 1'b0, 1'b0, "ldi");
        run_instr(5'b00100, 1'b0, 1'b0, "add");
        run_instr(5'b00110, 1'b0, 1'b0, "sub");
        run_instr(5'b00111, 1'b0, 1'b0, "subi");
        run_instr(5'b10100, 1'b0, 1'b0, "nop_undef");

        // Every branch/jump against every flag combination
        for (int op = 8; op <= 14; op++) begin
            for (int zn = 0; zn < 4; zn++) begin
                run_instr(5'(op), zn[1], zn[0], "branch");
            end
        end

        // run dropped during DECODE of SUB
        opcode_in = 5'b00110;
        tick("sub_fetch");
        run = 1'b0;
        tick("sub_decode");
        tick("sub_exec");
        tick("idle_wait");
        tick("idle_wait");
        run = 1'b1;
        tick("idle_to_fetch");

        // Reset asserted mid-EXECUTE
        opcode_in = 5'b00011;
        tick("ldi_fetch");
        tick("ldi_decode");
        control_reset = 1'b0;
        tick("ldi_exec_rst");
        control_reset = 1'b1;
        tick("init_after_abort");
        tick("idle_after_abort");

        // Randomised run/flags/opcodes with occasional resets
        for (int i = 0; i < 400; i++) begin
            run           = ($urandom_range(0, 9) != 0);
            flag_Z        = 1'($urandom_range(0, 1));
            flag_N        = 1'($urandom_range(0, 1));
            opcode_in     = TRAP ? 5'($urandom_range(1, 14)) : 5'($urandom_range(1, 31));
            control_reset = ($urandom_range(0, 49) != 0);
            tick("random");
        end

        // HLT parks the machine even with run high
        restart();
        run_instr(5'b00000, 1'b0, 1'b0, "hlt");
        repeat (4) tick("halt_hold");

        // Opcode 11111: trap or NOP depending on build
        restart();
        run_instr(5'b11111, 1'b0, 1'b0, "op_11111");
        repeat (3) tick("after_11111");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
